stopwatch_lap_core: RTL and testbench

//  Parametrised stopwatch core with a circular lap memory. It replaces the separate control FSM and

---
 rtl/stopwatch_lap_core_if.sv | 69 ++++++
 rtl/stopwatch_lap_core.sv | 178 +++++++++++++++++
 tb/tb_stopwatch_lap_core.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_lap_core_if.sv
// Command, live-time and lap-readout bundle for the stopwatch core.
// The master side issues commands and reads; the slave side is the core.
interface stopwatch_lap_core_if #(
  parameter int TICK_HZ   = 1000,
  parameter int LAP_DEPTH = 8
);
  localparam int FW = $clog2(TICK_HZ);
  localparam int AW = $clog2(LAP_DEPTH);

  logic          start_pause;
  logic          lap;
  logic          clear;
  logic          rd_req;
  logic [AW-1:0] rd_idx;

  logic [6:0]    hour;
  logic [5:0]    minute;
  logic [5:0]    second;
  logic [FW-1:0] frac;
  logic          running;
  logic          overflow;
  logic [AW:0]   lap_count;

  logic          rd_valid;
  logic [6:0]    rd_hour;
  logic [5:0]    rd_minute;
  logic [5:0]    rd_second;
  logic [FW-1:0] rd_frac;

  modport master (
    output start_pause,
    output lap,
    output clear,
    output rd_req,
    output rd_idx,
    input  hour,
    input  minute,
    input  second,
    input  frac,
    input  running,
    input  overflow,
    input  lap_count,
    input  rd_valid,
    input  rd_hour,
    input  rd_minute,
    input  rd_second,
    input  rd_frac
  );

  modport slave (
    input  start_pause,
    input  lap,
    input  clear,
    input  rd_req,
    input  rd_idx,
    output hour,
    output minute,
    output second,
    output frac,
    output running,
    output overflow,
    output lap_count,
    output rd_valid,
    output rd_hour,
    output rd_minute,
    output rd_second,
    output rd_frac
  );
endinterface

// File: rtl/stopwatch_lap_core.sv
// Stopwatch core: run/pause/hold control, HH:MM:SS.F time chain
// and a circular lap memory with registered random-access readout.
module stopwatch_lap_core #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 1000,
  parameter int HOUR_MAX  = 99,
  parameter int LAP_DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  stopwatch_lap_core_if.slave  bus
);
  localparam int FW  = $clog2(TICK_HZ);
  localparam int AW  = $clog2(LAP_DEPTH);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [FW-1:0] FMAX = FW'(TICK_HZ - 1);
  localparam logic [6:0]    HMAX = 7'(HOUR_MAX);
  localparam logic [5:0]    SMAX = 6'd59;
  localparam logic [AW:0]   CMAX = (AW+1)'(LAP_DEPTH);

  typedef struct packed {
    logic [6:0]    h;
    logic [5:0]    m;
    logic [5:0]    s;
    logic [FW-1:0] f;
  } stamp_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    HOLD
  } state_t;

  state_t        state;
  logic          running;
  logic          overflow;
  logic [PW-1:0] presc;
  stamp_t        now;
  stamp_t        nxt;
  stamp_t        mem [LAP_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          rd_ok;
  stamp_t        rd_data;

  logic          tick;
  logic          at_max;
  logic          clr;
  logic          sp;
  logic          do_lap;
  logic [AW-1:0] rd_slot;
  logic          rd_hit;

  // Clear outranks start_pause, which outranks lap.
  assign clr    = bus.clear;
  assign sp     = bus.start_pause & ~bus.clear;
  assign do_lap = bus.lap & ~bus.clear
                & ~bus.start_pause
                & (state == RUN);

  assign tick   = (state == RUN) && (presc == PMAX);
  assign at_max = (now == {HMAX, SMAX, SMAX, FMAX});

  assign rd_slot = wr_ptr - AW'(1) - bus.rd_idx;
  assign rd_hit  = ({1'b0, bus.rd_idx} < count);

  always_comb begin
    nxt = now;
    if (now.f != FMAX) begin
      nxt.f = now.f + FW'(1);
    end else begin
      nxt.f = '0;
      if (now.s != SMAX) begin
        nxt.s = now.s + 6'd1;
      end else begin
        nxt.s = '0;
        if (now.m != SMAX) begin
          nxt.m = now.m + 6'd1;
        end else begin
          nxt.m = '0;
          nxt.h = now.h + 7'd1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      running  <= 1'b0;
      overflow <= 1'b0;
      presc    <= '0;
      now      <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      rd_ok    <= 1'b0;
      rd_data  <= '0;
      for (int i = 0; i < LAP_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          presc <= '0;
          if (clr) begin
            wr_ptr <= '0;
            count  <= '0;
          end else if (sp) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (tick && at_max) begin
            state    <= HOLD;
            running  <= 1'b0;
            overflow <= 1'b1;
          end else begin
            if (tick)
              now <= nxt;
            if (sp) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
          end
        end
        PAUSE: begin
          if (clr) begin
            state <= IDLE;
            now   <= '0;
            presc <= '0;
          end else if (sp) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        HOLD: begin
          if (clr) begin
            state    <= IDLE;
            overflow <= 1'b0;
            now      <= '0;
            presc    <= '0;
          end
        end
        default: state <= IDLE;
      endcase

      // Snapshot is the pre-tick time of this cycle.
      if (do_lap) begin
        mem[wr_ptr] <= now;
        wr_ptr      <= wr_ptr + AW'(1);
        if (count != CMAX)
          count <= count + (AW+1)'(1);
      end

      rd_ok <= bus.rd_req & rd_hit;
      if (bus.rd_req)
        rd_data <= rd_hit ? mem[rd_slot] : '0;
    end
  end

  assign bus.hour      = now.h;
  assign bus.minute    = now.m;
  assign bus.second    = now.s;
  assign bus.frac      = now.f;
  assign bus.running   = running;
  assign bus.overflow  = overflow;
  assign bus.lap_count = count;
  assign bus.rd_valid  = rd_ok;
  assign bus.rd_hour   = rd_data.h;
  assign bus.rd_minute = rd_data.m;
  assign bus.rd_second = rd_data.s;
  assign bus.rd_frac   = rd_data.f;
endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Randomised bench for stopwatch_lap_core against a tick-count
// reference model with a queue of lap snapshots.
module tb_stopwatch_lap_core;
  localparam int CLK_HZ = 20;
  localparam int TICK_HZ = 10;
  localparam int HOUR_MAX = 0;
  localparam int LAP_DEPTH = 8;
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int MAXT =
    (HOUR_MAX * 3600 + 3599) * TICK_HZ + TICK_HZ - 1;

  logic clock;
  logic reset_n;

  stopwatch_lap_core_if #(
    .TICK_HZ(TICK_HZ),
    .LAP_DEPTH(LAP_DEPTH)
  ) bus ();

  stopwatch_lap_core #(
    .CLK_HZ(CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .HOUR_MAX(HOUR_MAX),
    .LAP_DEPTH(LAP_DEPTH)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nchk = 0;
  int nfail = 0;

  // Reference: mode 0 idle, 1 run, 2 pause, 3 hold.
  int mode;
  int mt;
  int mp;
  int lq[$];
  int erv;
  int erd;
  int lapt[10];

  task automatic check(input string tag,
                       input int obs, input int exp);
    nchk++;
    if (obs != exp) begin
      nfail++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic int dut_t();
    return bus.hour * 36000 + bus.minute * 600
         + bus.second * 10 + bus.frac;
  endfunction

  function automatic int dut_rd();
    return bus.rd_hour * 36000 + bus.rd_minute * 600
         + bus.rd_second * 10 + bus.rd_frac;
  endfunction

  task automatic model_reset();
    mode = 0;
    mt = 0;
    mp = 0;
    lq.delete();
    erv = 0;
    erd = 0;
  endtask

  task automatic model_step(input bit sp, input bit lp,
                            input bit cl, input bit rq,
                            input int idx);
    bit tk;
    if (rq) begin
      erv = (idx < lq.size()) ? 1 : 0;
      erd = erv ? lq[idx] : 0;
    end else begin
      erv = 0;
    end
    if (mode == 1 && lp && !sp && !cl) begin
      lq.push_front(mt);
      if (lq.size() > LAP_DEPTH)
        void'(lq.pop_back());
    end
    case (mode)
      0: begin
        mp = 0;
        if (cl) lq.delete();
        else if (sp) mode = 1;
      end
      1: begin
        tk = (mp == DIV - 1);
        mp = tk ? 0 : mp + 1;
        if (tk && mt == MAXT) begin
          mode = 3;
        end else begin
          if (tk) mt++;
          if (sp && !cl) mode = 2;
        end
      end
      2: begin
        if (cl) begin
          mode = 0; mt = 0; mp = 0;
        end else if (sp) begin
          mode = 1;
        end
      end
      default: begin
        if (cl) begin
          mode = 0; mt = 0; mp = 0;
        end
      end
    endcase
  endtask

  task automatic cyc(input bit sp = 0, input bit lp = 0,
                     input bit cl = 0, input bit rq = 0,
                     input int idx = 0);
    bus.start_pause = sp;
    bus.lap = lp;
    bus.clear = cl;
    bus.rd_req = rq;
    bus.rd_idx = 3'(idx);
    @(posedge clock);
    model_step(sp, lp, cl, rq, idx);
    @(negedge clock);
    bus.start_pause = 0;
    bus.lap = 0;
    bus.clear = 0;
    bus.rd_req = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_hour"}, bus.hour, mt / 36000);
    check({tag, "_min"}, bus.minute, (mt / 600) % 60);
    check({tag, "_sec"}, bus.second, (mt / 10) % 60);
    check({tag, "_frac"}, bus.frac, mt % 10);
    check({tag, "_run"}, bus.running, mode == 1);
    check({tag, "_ovf"}, bus.overflow, mode == 3);
    check({tag, "_cnt"}, bus.lap_count, lq.size());
    check({tag, "_rdv"}, bus.rd_valid, erv);
    check({tag, "_rdt"}, dut_rd(), erd);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    bus.start_pause = 0;
    bus.lap = 0;
    bus.clear = 0;
    bus.rd_req = 0;
    bus.rd_idx = '0;
    reset_n = 0;
    model_reset();
    repeat (3) @(negedge clock);
    check_all("rst");
    reset_n = 1;

    cyc(1);
    repeat (40) cyc();
    check_all("t1");
    check("t1_sec2", bus.second, 2);
    check("t1_running", bus.running, 1);

    for (int i = 0; i < 2000 && mt != 599; i++) cyc();
    check("t2_reach", dut_t(), 599);
    cyc();
    cyc();
    check("t2_min", bus.minute, 1);
    check("t2_sec", bus.second, 0);
    check("t2_frac", bus.frac, 0);
    check_all("t2");

    cyc();
    cyc();
    cyc(1);
    saved = mt;
    repeat (100) cyc();
    check("t3_hold", dut_t(), saved);
    check("t3_paused", bus.running, 0);
    cyc(1);
    check("t3_resume", dut_t(), saved);
    cyc();
    check("t3_tick", dut_t(), saved + 1);
    check_all("t3");

    for (int k = 0; k < 10; k++) begin
      lapt[k] = mt;
      cyc(0, 1);
      cyc();
    end
    check("t4_count", bus.lap_count, LAP_DEPTH);
    cyc(0, 0, 0, 1, 0);
    check("t4_rd0_v", bus.rd_valid, 1);
    check("t4_rd0", dut_rd(), lapt[9]);
    check_all("t4a");
    cyc(0, 0, 0, 1, 7);
    check("t4_rd7_v", bus.rd_valid, 1);
    check("t4_rd7", dut_rd(), lapt[2]);
    cyc();
    check("t4_norq_v", bus.rd_valid, 0);
    check("t4_norq_hold", dut_rd(), lapt[2]);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 19) == 0,
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 24) == 0,
          $urandom_range(0, 1) == 1,
          int'($urandom_range(0, 7)));
      check_all("rnd");
    end

    for (int i = 0; i < 4 && mode != 0; i++) begin
      if (mode == 1) cyc(1);
      else cyc(0, 0, 1);
    end
    check("t5_idle", bus.running | bus.overflow, 0);
    cyc(1);
    for (int i = 0; i < 80000 && mt != MAXT; i++) begin
      cyc();
      if ((i % 4096) == 0) check_all("t5run");
    end
    check("t5_reach", dut_t(), MAXT);
    cyc();
    cyc();
    check("t5_ovf", bus.overflow, 1);
    check("t5_run0", bus.running, 0);
    check("t5_max", dut_t(), MAXT);
    cyc(1);
    repeat (5) cyc();
    check("t5_frozen", dut_t(), MAXT);
    check("t5_still", bus.overflow, 1);
    check_all("t5h");
    cyc(0, 0, 1);
    check("t5_clr", dut_t(), 0);
    check("t5_clr_ovf", bus.overflow, 0);
    check_all("t5c");

    cyc(1);
    repeat (5) cyc();
    #2;
    reset_n = 0;
    #1;
    model_reset();
    check("t6_async_t", dut_t(), 0);
    check_all("t6r");
    @(posedge clock);
    @(negedge clock);
    reset_n = 1;
    cyc(1);
    repeat (3) cyc();
    cyc(1);
    check("t6_paused", bus.running, 0);
    cyc(1, 0, 1);
    check("t6_idle_t", dut_t(), 0);
    check_all("t6");
    cyc(1);
    check("t6_restart", bus.running, 1);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
